// File: rtl/descriptor_mem_arbiter_if.sv
// descriptor_mem_arbiter_if: the A and B Avalon-MM requester buses plus the
// single RAM port, bundled into one interface.
// slave modport  = arbiter view, master modport = requesters + RAM view.
// The a_lock/b_lock sideband exists only when DESC_MEM_ARB_LOCK_EN is defined.
interface descriptor_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] a_address;
  logic [BE_W-1:0]   a_byteenable;
  logic              a_read;
  logic              a_write;
  logic [DATA_W-1:0] a_writedata;
  logic [DATA_W-1:0] a_readdata;
  logic              a_readdatavalid;
  logic              a_waitrequest;

  logic [ADDR_W-1:0] b_address;
  logic [BE_W-1:0]   b_byteenable;
  logic              b_read;
  logic              b_write;
  logic [DATA_W-1:0] b_writedata;
  logic [DATA_W-1:0] b_readdata;
  logic              b_readdatavalid;
  logic              b_waitrequest;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;

`ifdef DESC_MEM_ARB_LOCK_EN
  logic a_lock;
  logic b_lock;
`endif

  modport slave (
`ifdef DESC_MEM_ARB_LOCK_EN
    input  a_lock, b_lock,
`endif
    input  a_address, a_byteenable, a_read, a_write, a_writedata,
    output a_readdata, a_readdatavalid, a_waitrequest,
    input  b_address, b_byteenable, b_read, b_write, b_writedata,
    output b_readdata, b_readdatavalid, b_waitrequest,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
    input  mem_readdata
  );

  modport master (
`ifdef DESC_MEM_ARB_LOCK_EN
    output a_lock, b_lock,
`endif
    output a_address, a_byteenable, a_read, a_write, a_writedata,
    input  a_readdata, a_readdatavalid, a_waitrequest,
    output b_address, b_byteenable, b_read, b_write, b_writedata,
    input  b_readdata, b_readdatavalid, b_waitrequest,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
    output mem_readdata
  );
endinterface

// File: rtl/descriptor_mem_arbiter.sv
// descriptor_mem_arbiter: two-requester arbiter (A = CPU slave path,
// B = DMA descriptor path) in front of a single-port RAM with registered
// address and unregistered q. Combinational grant, one transaction per
// cycle, fixed read latency of 2 with in-order return per port.
// Optional bus lock: define DESC_MEM_ARB_LOCK_EN.

// Per-port read-data holding register; loads only when this port owns the
// read coming back from the RAM, otherwise keeps its previous value.
module desc_mem_arb_rdport #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cap,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  // capture RAM q for the owning port
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)  q <= '0;
    else if (cap)  q <= d;
endmodule

module descriptor_mem_arbiter #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 32,
  parameter int PRIORITY_MODE = 0
) (
  input logic                     clk,
  input logic                     reset_n,
  descriptor_mem_arbiter_if.slave bus
);
  localparam int NUM_PORTS = 2;   // bit 0 = A, bit 1 = B
  localparam int STAGES    = 2;   // read latency in cycles
  localparam int BE_W      = DATA_W / 8;

  logic [NUM_PORTS-1:0] req, rd, elig, gnt;
  logic                 last_grant;  // 1 = B granted last
  logic [STAGES:0]      vld_pipe;
  logic [STAGES:0]      pid_pipe;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;
  logic [NUM_PORTS-1:0] rvld;
  logic [ADDR_W-1:0]    addr_mux;
  logic [BE_W-1:0]      be_mux;

  // read+write together counts as a write with no response
  assign req = {bus.b_read | bus.b_write, bus.a_read | bus.a_write};
  assign rd  = {bus.b_read & ~bus.b_write, bus.a_read & ~bus.a_write};

`ifdef DESC_MEM_ARB_LOCK_EN
  logic [NUM_PORTS-1:0] lock_owner;  // one-hot, 0 = unlocked
  logic [NUM_PORTS-1:0] lock_in;
  assign lock_in = {bus.b_lock, bus.a_lock};
  // while locked, the non-owner is not eligible at all
  assign elig    = req & ~{lock_owner[0], lock_owner[1]};

  // a granted locked transaction takes the lock, a granted unlocked one drops it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)    lock_owner <= '0;
    else if (gnt[0]) lock_owner <= lock_in[0] ? 2'b01 : 2'b00;
    else if (gnt[1]) lock_owner <= lock_in[1] ? 2'b10 : 2'b00;
`else
  assign elig = req;
`endif

  // same-cycle grant; no grant at all while reset is asserted
  always_comb begin
    gnt = '0;
    if (reset_n) begin
      if (&elig) begin
        if (PRIORITY_MODE == 1 || last_grant) gnt = 2'b01;
        else                                  gnt = 2'b10;
      end else begin
        gnt = elig;
      end
    end
  end

  // remember the winner for round-robin; reset favours A on first contention
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)  last_grant <= 1'b1;
    else if (|gnt) last_grant <= gnt[1];

  assign bus.a_waitrequest = req[0] & ~gnt[0];
  assign bus.b_waitrequest = req[1] & ~gnt[1];

  // RAM drive; A's buses are presented when idle
  assign addr_mux           = gnt[1] ? bus.b_address    : bus.a_address;
  assign be_mux             = gnt[1] ? bus.b_byteenable : bus.a_byteenable;
  assign bus.mem_address    = addr_mux;
  assign bus.mem_byteenable = be_mux;
  assign bus.mem_writedata  = gnt[1] ? bus.b_writedata  : bus.a_writedata;
  assign bus.mem_chipselect = |gnt;
  assign bus.mem_write      = gnt[1] ? bus.b_write : (gnt[0] & bus.a_write);

  // stage 0 is the accept cycle; stage 1 = RAM q valid; stage 2 = readdatavalid
  assign vld_pipe[0] = |(gnt & rd);
  assign pid_pipe[0] = gnt[1];

  // read return pipeline: {valid, owner} shifted each cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vld_pipe[STAGES:1] <= '0;
      pid_pipe[STAGES:1] <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      pid_pipe[STAGES:1] <= pid_pipe[STAGES-1:0];
    end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    desc_mem_arb_rdport #(.DATA_W(DATA_W)) u_rd (
      .clk     (clk),
      .reset_n (reset_n),
      .cap     (vld_pipe[1] & (pid_pipe[1] == 1'(g))),
      .d       (bus.mem_readdata),
      .q       (rdata[g])
    );
    assign rvld[g] = vld_pipe[STAGES] & (pid_pipe[STAGES] == 1'(g));
  end

  assign bus.a_readdata      = rdata[0];
  assign bus.b_readdata      = rdata[1];
  assign bus.a_readdatavalid = rvld[0];
  assign bus.b_readdatavalid = rvld[1];
endmodule

// File: doc/descriptor_mem_arbiter.md
Name: descriptor_mem_arbiter

Overview:
- Two-requester arbiter in front of the single-port 1024x32 descriptor RAM.
- Requester A is the CPU-side Avalon-MM slave path; requester B is the DMA descriptor-fetch/writeback path.
- Serialises their reads and writes onto the RAM's one port, returns read data to the correct requester, and keeps one transaction per cycle throughput.

Parameters:
- ADDR_W, 10, word address width (RAM depth 2^ADDR_W).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (A always wins).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- a_address  in  ADDR_W  A word address.
- a_byteenable  in  DATA_W/8  A byte lanes.
- a_read  in  1  A read request.
- a_write  in  1  A write request.
- a_writedata  in  DATA_W  A write data.
- a_readdata  out  DATA_W  A read data.
- a_readdatavalid  out  1  A read data valid.
- a_waitrequest  out  1  A stall.
- b_address, b_byteenable, b_read, b_write, b_writedata, b_readdata, b_readdatavalid, b_waitrequest: same as A, for B.
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  DATA_W/8  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  DATA_W  to RAM.
- mem_readdata  in  DATA_W  RAM q (unregistered output, registered address).
- RAM clken is tied high at integration.

Behaviour:
- Reset is asynchronous; all registers clear immediately on reset_n low:
  - readdata = 0, readdatavalid = 0, pipeline valid bits = 0.
  - last_grant = B, so A wins the first contention.
- While reset_n is low, grants are 0 and waitrequest = request.
- Request definitions: x_req = x_read | x_write. If read and write are both high, the request is a write and no readdatavalid is produced.
- Grant is combinational in the same cycle:
  - Only one port requesting: it is granted.
  - Both requesting, PRIORITY_MODE=0: the port not equal to last_grant wins.
  - Both requesting, PRIORITY_MODE=1: A wins.
  - last_grant updates on every granted cycle.
- x_waitrequest = x_req & ~x_grant. It is combinational; a granted transaction is accepted in that cycle.
- Memory drive:
  - mem_chipselect = any grant.
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted port.
  - mem_write = granted write.
  - With no grant, the mem_* buses hold A's values and chipselect = 0.
- Read pipeline (cycle N = accepted):
  - Stage 1 registers {valid, port id} at the end of N.
  - In N+1, mem_readdata is captured into the owning port's readdata register.
  - x_readdatavalid pulses high for exactly one cycle in N+2.
  - Fixed latency 2, throughput one read per cycle, reads returned in order per port.
  - The non-owning port's readdata holds its previous value.
- Writes: committed at the end of cycle N; no response.
- Read-after-write to the same address, issued in the next cycle: returns the new data, because the RAM is single-port and the accesses are serialised.
- Back-to-back contention in round-robin mode alternates A,B,A,B. A port never stalls more than 1 consecutive cycle (PRIORITY_MODE=1: B may starve).
- Reset mid-operation: in-flight reads are dropped and no readdatavalid is produced afterwards. Writes accepted before the reset edge are kept.
- Requester contract: must hold address, data and command stable while waitrequest is high. The arbiter does not latch ungranted requests.

Optional Feature:
- Macro DESC_MEM_ARB_LOCK_EN.
- Defined:
  - Adds inputs a_lock and b_lock (1 bit each), plus a lock_owner register (reset: none).
  - A granted transaction with x_lock=1 sets lock_owner = x.
  - While locked, only the owner can be granted; the other port's waitrequest stays high.
  - The lock releases on the first granted owner transaction with x_lock=0.
  - lock is ignored on cycles without a request.
- Undefined: no lock ports, pure arbitration as above.

Test Plan:
- Reset, then A writes 0xDEADBEEF to address 0x010 with byteenable 0xF, then A reads 0x010 -> a_readdatavalid high exactly 2 cycles after acceptance, a_readdata=0xDEADBEEF, b_readdatavalid stays 0.
- A and B both read continuously (A at 0x001, B at 0x002; RAM preloaded 0x11111111 and 0x22222222), PRIORITY_MODE=0 -> grants alternate A,B,A,B, starting with A; each readdatavalid returns the correct value, 2 cycles after its accept.
- B writes byteenable 0x3, data 0xAAAA5555 to a word preloaded 0x12345678, then reads it -> 0x12345555.
- PRIORITY_MODE=1, both requesting for 8 cycles -> a_waitrequest=0 throughout, b_waitrequest=1 throughout, no B accepts.
- Assert reset_n low one cycle after a read is accepted -> no readdatavalid on either port, outputs 0; after release the first contention goes to A.
- DESC_MEM_ARB_LOCK_EN defined: B issues a locked read, A requests, B does 3 more locked ops, then one unlocked -> A stalled for all 5 B transactions, granted the next cycle.
